// File: rtl/bsg_gray_ptr_status.sv
// One domain's half of an async FIFO pointer pair: local binary/Gray pointers,
// decoded peer pointer, occupancy, full/empty and a sticky error flag.
module bsg_gray_ptr_status #(
    parameter int lg_size_p    = 6,
    parameter int write_side_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               inc_i,
    input  logic [lg_size_p:0] remote_ptr_gray_i,
    output logic               inc_accept_o,
    output logic [lg_size_p:0] ptr_binary_r_o,
    output logic [lg_size_p:0] ptr_gray_r_o,
    output logic [lg_size_p:0] remote_ptr_binary_r_o,
    output logic [lg_size_p:0] count_o,
    output logic               full_o,
    output logic               empty_o,
    output logic               error_o
);

    localparam int ptr_width_lp = lg_size_p + 1;
    localparam logic [lg_size_p:0] depth_lp = {1'b1, {lg_size_p{1'b0}}};

    logic [lg_size_p:0] ptr_binary_reg;
    logic [lg_size_p:0] ptr_gray_reg;
    logic [lg_size_p:0] remote_binary_reg;
    logic               error_reg;

    logic [lg_size_p:0] binary_next;
    logic [lg_size_p:0] gray_next;
    logic [lg_size_p:0] remote_binary_next;
    logic [lg_size_p:0] count;
    logic               full;
    logic               empty;
    logic               blocking;
    logic               inc_accept;
    logic               error_next;

    // Gray is derived from the next binary value so the register flips one bit per step.
    assign binary_next = ptr_binary_reg + ptr_width_lp'(1);
    assign gray_next   = binary_next ^ (binary_next >> 1);

    // Each binary bit is the XOR of all Gray bits at or above it.
    generate
        for (genvar gi = 0; gi < ptr_width_lp; gi++) begin : g_decode
            assign remote_binary_next[gi] = ^remote_ptr_gray_i[lg_size_p:gi];
        end
    endgenerate

    generate
        if (write_side_p != 0) begin : g_write_count
            assign count    = ptr_binary_reg - remote_binary_reg;
            assign blocking = full;
        end else begin : g_read_count
            assign count    = remote_binary_reg - ptr_binary_reg;
            assign blocking = empty;
        end
    endgenerate

    assign full       = (count == depth_lp);
    assign empty      = (count == '0);
    assign inc_accept = inc_i & ~blocking & ~reset_i;
    assign error_next = error_reg | (inc_i & blocking) | (count > depth_lp);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_binary_reg    <= '0;
            ptr_gray_reg      <= '0;
            remote_binary_reg <= '0;
            error_reg         <= 1'b0;
        end else begin
            if (inc_accept) begin
                ptr_binary_reg <= binary_next;
                ptr_gray_reg   <= gray_next;
            end
            remote_binary_reg <= remote_binary_next;
            error_reg         <= error_next;
        end
    end

    assign inc_accept_o          = inc_accept;
    assign ptr_binary_r_o        = ptr_binary_reg;
    assign ptr_gray_r_o          = ptr_gray_reg;
    assign remote_ptr_binary_r_o = remote_binary_reg;
    assign count_o               = count;
    assign full_o                = full;
    assign empty_o               = empty;
    assign error_o               = error_reg;

endmodule

// File: tb/tb_bsg_gray_ptr_status.sv
// Scoreboard bench for bsg_gray_ptr_status: one write-side and one read-side
// instance, directed vectors queued with expected results, checked by a monitor.
module tb_bsg_gray_ptr_status;

    localparam int W = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_w, inc_w, rst_r, inc_r;
    logic [W-1:0] rg_w, rg_r;
    logic         acc_w, full_w, empty_w, err_w;
    logic         acc_r, full_r, empty_r, err_r;
    logic [W-1:0] bin_w, gray_w, rbin_w, cnt_w;
    logic [W-1:0] bin_r, gray_r, rbin_r, cnt_r;

    bsg_gray_ptr_status #(.lg_size_p(6), .write_side_p(1)) dut_w (
        .clk_i(clk), .reset_i(rst_w), .inc_i(inc_w), .remote_ptr_gray_i(rg_w),
        .inc_accept_o(acc_w), .ptr_binary_r_o(bin_w), .ptr_gray_r_o(gray_w),
        .remote_ptr_binary_r_o(rbin_w), .count_o(cnt_w), .full_o(full_w),
        .empty_o(empty_w), .error_o(err_w)
    );

    bsg_gray_ptr_status #(.lg_size_p(6), .write_side_p(0)) dut_r (
        .clk_i(clk), .reset_i(rst_r), .inc_i(inc_r), .remote_ptr_gray_i(rg_r),
        .inc_accept_o(acc_r), .ptr_binary_r_o(bin_r), .ptr_gray_r_o(gray_r),
        .remote_ptr_binary_r_o(rbin_r), .count_o(cnt_r), .full_o(full_r),
        .empty_o(empty_r), .error_o(err_r)
    );

    typedef struct {
        bit           side;
        int           due;
        string        name;
        bit           acc;
        logic [W-1:0] bin, gray, rbin, cnt;
        bit           full, empty, err;
    } exp_t;

    exp_t sb[$];
    int   neg_cnt = 0;
    int   n_vec   = 0;
    int   n_bad   = 0;

    function automatic logic [W-1:0] to_gray(input int b);
        logic [W-1:0] v;
        v = W'(b);
        return v ^ (v >> 1);
    endfunction

    // Drive one cycle of stimulus on the chosen side; expectation covers the
    // accept seen this cycle and the registered outputs on the following cycle.
    task automatic vec(input bit side, input bit rst, input bit inc, input int rbin_in,
                       input string name, input bit e_acc, input int e_bin, input int e_rbin,
                       input int e_cnt, input bit e_full, input bit e_empty, input bit e_err);
        exp_t e;
        @(posedge clk);
        #1;
        if (side) begin
            rst_w = rst; inc_w = inc; rg_w = to_gray(rbin_in);
            inc_r = 1'b0; rst_r = 1'b0;
        end else begin
            rst_r = rst; inc_r = inc; rg_r = to_gray(rbin_in);
            inc_w = 1'b0; rst_w = 1'b0;
        end
        e.side = side; e.due = neg_cnt + 2; e.name = name; e.acc = e_acc;
        e.bin = W'(e_bin); e.gray = to_gray(e_bin); e.rbin = W'(e_rbin); e.cnt = W'(e_cnt);
        e.full = e_full; e.empty = e_empty; e.err = e_err;
        sb.push_back(e);
    endtask

    // Monitor: checks due expectations and Gray single-bit stepping.
    bit           acc_prev_w, acc_prev_r;
    logic         rst_prev_w, rst_prev_r;
    logic [W-1:0] gray_prev_w, gray_prev_r;
    initial begin
        exp_t e;
        bit a_acc, a_full, a_empty, a_err;
        logic [W-1:0] a_bin, a_gray, a_rbin, a_cnt;
        forever begin
            @(negedge clk);
            neg_cnt++;
            if (rst_prev_w == 1'b0 && gray_w !== gray_prev_w) begin
                n_vec++;
                if ($countones(gray_w ^ gray_prev_w) != 1) begin
                    n_bad++;
                    $display("FAIL gray_step_w: got %b after %b, required one bit change", gray_w, gray_prev_w);
                end
            end
            if (rst_prev_r == 1'b0 && gray_r !== gray_prev_r) begin
                n_vec++;
                if ($countones(gray_r ^ gray_prev_r) != 1) begin
                    n_bad++;
                    $display("FAIL gray_step_r: got %b after %b, required one bit change", gray_r, gray_prev_r);
                end
            end
            while (sb.size() > 0 && sb[0].due == neg_cnt) begin
                e = sb.pop_front();
                if (e.side) begin
                    a_acc = acc_prev_w; a_bin = bin_w; a_gray = gray_w; a_rbin = rbin_w;
                    a_cnt = cnt_w; a_full = full_w; a_empty = empty_w; a_err = err_w;
                end else begin
                    a_acc = acc_prev_r; a_bin = bin_r; a_gray = gray_r; a_rbin = rbin_r;
                    a_cnt = cnt_r; a_full = full_r; a_empty = empty_r; a_err = err_r;
                end
                n_vec++;
                if (a_acc !== e.acc || a_bin !== e.bin || a_gray !== e.gray || a_rbin !== e.rbin ||
                    a_cnt !== e.cnt || a_full !== e.full || a_empty !== e.empty || a_err !== e.err) begin
                    n_bad++;
                    $display("FAIL %s: got acc=%b bin=%0d gray=%b rbin=%0d cnt=%0d full=%b empty=%b err=%b, required acc=%b bin=%0d gray=%b rbin=%0d cnt=%0d full=%b empty=%b err=%b",
                             e.name, a_acc, a_bin, a_gray, a_rbin, a_cnt, a_full, a_empty, a_err,
                             e.acc, e.bin, e.gray, e.rbin, e.cnt, e.full, e.empty, e.err);
                end
            end
            acc_prev_w  = acc_w;  acc_prev_r  = acc_r;
            rst_prev_w  = rst_w;  rst_prev_r  = rst_r;
            gray_prev_w = gray_w; gray_prev_r = gray_r;
        end
    end

    initial begin
        rst_w = 1'b1; inc_w = 1'b0; rg_w = '0;
        rst_r = 1'b1; inc_r = 1'b0; rg_r = '0;
        repeat (2) @(posedge clk);

        // Reset with inc held high on both sides
        vec(1, 1, 1, 0, "reset_w", 0, 0, 0, 0, 0, 1, 0);
        vec(0, 1, 1, 0, "reset_r", 0, 0, 0, 0, 0, 1, 0);

        // Fill the write side to 64, then one blocked increment
        for (int i = 1; i <= 64; i++)
            vec(1, 0, 1, 0, $sformatf("fill_%0d", i), 1, i, 0, i, (i == 64), 0, 0);
        vec(1, 0, 1, 0, "fill_blocked", 0, 64, 0, 64, 1, 0, 1);

        // Drain the read side from remote = 5
        vec(0, 0, 0, 5, "drain_remote", 0, 0, 5, 5, 0, 0, 0);
        for (int i = 1; i <= 5; i++)
            vec(0, 0, 1, 5, $sformatf("drain_%0d", i), 1, i, 5, 5 - i, 0, (i == 5), 0);
        vec(0, 0, 1, 5, "drain_blocked", 0, 5, 5, 0, 0, 1, 1);

        // Corrupt remote: local 0, remote 10 -> count 118 sets sticky error
        vec(1, 1, 0, 0, "reset_w2", 0, 0, 0, 0, 0, 1, 0);
        vec(1, 0, 0, 10, "corrupt_remote", 0, 0, 10, 118, 0, 0, 0);
        vec(1, 0, 0, 0, "corrupt_err", 0, 0, 0, 0, 0, 1, 1);
        vec(1, 0, 0, 0, "corrupt_sticky", 0, 0, 0, 0, 0, 1, 1);

        // Advance to 37 with error still set, then reset with inc and nonzero remote
        for (int i = 1; i <= 37; i++)
            vec(1, 0, 1, 0, $sformatf("adv_%0d", i), 1, i, 0, i, 0, 0, 1);
        vec(1, 1, 1, 20, "reset_mid", 0, 0, 0, 0, 0, 1, 0);
        vec(1, 0, 0, 0, "after_reset_mid", 0, 0, 0, 0, 0, 1, 0);

        // Wrap: remote kept 10 behind local across 127 -> 0
        for (int i = 1; i <= 128; i++)
            vec(1, 0, 1, (i + 118) % 128, $sformatf("wrap_%0d", i), 1, i % 128, (i + 118) % 128, 10, 0, 0, 0);

        vec(1, 0, 0, 118, "idle_end", 0, 0, 118, 10, 0, 0, 0);

        repeat (4) @(negedge clk);
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_queue: got %0d pending expectations, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
